// File: rtl/alarm_unit_if.sv
// Signal bundle between the clock counters / key debouncers and the alarm stage,
// plus the alarm outputs toward the display mux and buzzer pin.
interface alarm_unit_if;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic       second_flag;
  logic       alarm_enable;
  logic       key_set;
  logic       key_add;
  logic       key_stop;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_minute;
  logic [1:0] setting;
  logic       ringing;
  logic       snoozing;
  logic       buzzer;

  modport master (
    output hour, minute, second, second_flag, alarm_enable, key_set, key_add, key_stop,
    input  alarm_hour, alarm_minute, setting, ringing, snoozing, buzzer
  );

  modport slave (
    input  hour, minute, second, second_flag, alarm_enable, key_set, key_add, key_stop,
    output alarm_hour, alarm_minute, setting, ringing, snoozing, buzzer
  );
endinterface

// File: rtl/alarm_unit.sv
// Daily alarm: stores a user-set alarm time, rings a gated square-wave buzzer on the
// rising edge of a time match, with snooze and auto-dismiss after a fixed ring time.
module alarm_unit #(
  parameter int unsigned HOUR_INIT      = 7,
  parameter int unsigned MINUTE_INIT    = 0,
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_MINUTES = 5,
  parameter int unsigned TONE_DIV       = 16
) (
  input  logic         clock,
  input  logic         reset,
  alarm_unit_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SET_HOUR, SET_MINUTE, RINGING, SNOOZE} state_t;

  localparam int unsigned      TONE_W      = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [TONE_W-1:0] TONE_LAST  = TONE_W'(TONE_DIV - 1);
  localparam logic [6:0]        RING_LAST  = 7'(RING_SECONDS - 1);
  localparam logic [9:0]        SNOOZE_LOAD = 10'(SNOOZE_MINUTES * 60);

  state_t            state;
  logic [4:0]        alarm_hour;
  logic [5:0]        alarm_minute;
  logic [6:0]        ring_cnt;
  logic [9:0]        snooze_cnt;
  logic [TONE_W-1:0] tone_cnt;
  logic              tone_bit;
  logic              match_d;
  logic              match;
  logic              match_pulse;

  // Only the rising edge of match fires, so leaving SET_* during a match stays silent.
  assign match       = (bus.hour == alarm_hour) && (bus.minute == alarm_minute) &&
                       (bus.second == 6'd0);
  assign match_pulse = match && !match_d;

  // NOTE: every state element sits in one clocked block with non-blocking assignments;
  // a later <= to the same register in this block overrides an earlier one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      alarm_hour   <= 5'(HOUR_INIT);
      alarm_minute <= 6'(MINUTE_INIT);
      ring_cnt     <= '0;
      snooze_cnt   <= '0;
      tone_cnt     <= '0;
      tone_bit     <= 1'b0;
      match_d      <= 1'b0;
    end else begin
      match_d <= match;
      case (state)
        IDLE: begin
          if (bus.key_set) begin
            state <= SET_HOUR;
          end else if (match_pulse && bus.alarm_enable) begin
            state    <= RINGING;
            ring_cnt <= '0;
            tone_cnt <= '0;
            tone_bit <= 1'b0;
          end
        end
        SET_HOUR: begin
          if (bus.key_set) begin
            state <= SET_MINUTE;
          end else if (bus.key_add) begin
            alarm_hour <= (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
          end
        end
        SET_MINUTE: begin
          if (bus.key_set) begin
            state <= IDLE;
          end else if (bus.key_add) begin
            alarm_minute <= (alarm_minute == 6'd59) ? 6'd0 : alarm_minute + 6'd1;
          end
        end
        RINGING: begin
          if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone_bit <= ~tone_bit;
          end else begin
            tone_cnt <= tone_cnt + TONE_W'(1);
          end
          // Any exit parks the tone generator at zero so the next ring restarts in phase.
          if (!bus.alarm_enable || bus.key_set) begin
            state    <= IDLE;
            tone_cnt <= '0;
            tone_bit <= 1'b0;
          end else if (bus.key_stop) begin
            state      <= SNOOZE;
            snooze_cnt <= SNOOZE_LOAD;
            tone_cnt   <= '0;
            tone_bit   <= 1'b0;
          end else if (bus.second_flag) begin
            if (ring_cnt == RING_LAST) begin
              state    <= IDLE;
              tone_cnt <= '0;
              tone_bit <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 7'd1;
            end
          end
        end
        SNOOZE: begin
          if (!bus.alarm_enable || bus.key_set) begin
            state <= IDLE;
          end else if (bus.second_flag) begin
            if (snooze_cnt == 10'd1) begin
              state    <= RINGING;
              ring_cnt <= '0;
            end else begin
              snooze_cnt <= snooze_cnt - 10'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alarm_hour   = alarm_hour;
  assign bus.alarm_minute = alarm_minute;
  assign bus.setting      = (state == SET_HOUR)   ? 2'd1 :
                            (state == SET_MINUTE) ? 2'd2 : 2'd0;
  assign bus.ringing      = (state == RINGING);
  assign bus.snoozing     = (state == SNOOZE);
  // Odd ring seconds are silent, giving a 1 s beep / 1 s pause cadence.
  assign bus.buzzer       = (state == RINGING) && tone_bit && !ring_cnt[0];

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit: stimulus queues expected output values with a due cycle,
// a monitor on the falling edge pops and compares them.
module tb_alarm_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  alarm_unit_if bus ();

  alarm_unit #(
    .HOUR_INIT(7), .MINUTE_INIT(0), .RING_SECONDS(60), .SNOOZE_MINUTES(5), .TONE_DIV(16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum {F_AH, F_AM, F_SET, F_RING, F_SNZ, F_BUZ} field_t;
  typedef struct {
    int     due;
    field_t field;
    int     value;
    string  name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int observe(field_t f);
    case (f)
      F_AH:   return int'(bus.alarm_hour);
      F_AM:   return int'(bus.alarm_minute);
      F_SET:  return int'(bus.setting);
      F_RING: return int'(bus.ringing);
      F_SNZ:  return int'(bus.snoozing);
      default: return int'(bus.buzzer);
    endcase
  endfunction

  // Queue an expectation, compared at the falling edge `delay` cycles from now.
  task automatic check(input field_t f, input int value, input string name, input int delay = 0);
    exp_t e;
    e.due   = cyc + delay;
    e.field = f;
    e.value = value;
    e.name  = name;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        int act;
        act = observe(sb[i].field);
        checks++;
        if (sb[i].due < cyc) begin
          errors++;
          $display("FAIL %s: comparison missed its cycle %0d (now %0d)", sb[i].name, sb[i].due, cyc);
        end else if (act != sb[i].value) begin
          errors++;
          $display("FAIL %s: actual %0d required %0d at cycle %0d", sb[i].name, act, sb[i].value, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse(input logic s, input logic a, input logic p);
    bus.key_set  = s;
    bus.key_add  = a;
    bus.key_stop = p;
    step();
    bus.key_set  = 1'b0;
    bus.key_add  = 1'b0;
    bus.key_stop = 1'b0;
  endtask

  task automatic flag();
    bus.second_flag = 1'b1;
    step();
    bus.second_flag = 1'b0;
    step();
  endtask

  // Produce a fresh rising edge of the time match (alarm time must equal hour:minute).
  task automatic match_edge();
    bus.second = 6'd59;
    step(2);
    bus.second = 6'd0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hour = 5'd0; bus.minute = 6'd0; bus.second = 6'd1;
    bus.second_flag = 1'b0; bus.alarm_enable = 1'b0;
    bus.key_set = 1'b0; bus.key_add = 1'b0; bus.key_stop = 1'b0;
    step(3);
    check(F_AH, 7, "reset_alarm_hour");
    check(F_AM, 0, "reset_alarm_minute");
    check(F_SET, 0, "reset_setting");
    check(F_RING, 0, "reset_ringing");
    check(F_SNZ, 0, "reset_snoozing");
    check(F_BUZ, 0, "reset_buzzer");
    reset = 1'b1;
    step(2);

    // Ring on the 07:00:00 edge; tone first toggles 16 cycles after entry.
    bus.alarm_enable = 1'b1; bus.hour = 5'd7; bus.minute = 6'd0; bus.second = 6'd59;
    step();
    check(F_RING, 0, "ring_before_match");
    bus.second = 6'd0;
    step();
    check(F_RING, 1, "ring_on_match");
    check(F_BUZ, 0, "buzz_before_first_toggle", 15);
    check(F_BUZ, 1, "buzz_first_toggle", 16);
    check(F_BUZ, 0, "buzz_second_toggle", 32);
    step(33);

    // Auto-dismiss after 60 second flags; odd seconds silent.
    flag();
    check(F_BUZ, 0, "buzz_odd_second_a");
    check(F_BUZ, 0, "buzz_odd_second_b", 16);
    step(16);
    repeat (58) flag();
    check(F_RING, 1, "ring_before_timeout");
    flag();
    check(F_RING, 0, "ring_timeout");
    check(F_BUZ, 0, "buzz_after_timeout");
    step(3);
    check(F_RING, 0, "no_retrigger_after_timeout");

    pulse(1'b0, 1'b1, 1'b0);
    check(F_AH, 7, "add_ignored_idle");
    check(F_SET, 0, "add_no_setting_idle");

    // Set alarm to 10:59, then wrap minute to 0.
    bus.second = 6'd1;
    pulse(1'b1, 1'b0, 1'b0);
    check(F_SET, 1, "setting_hour");
    repeat (3) pulse(1'b0, 1'b1, 1'b0);
    check(F_AH, 10, "hour_plus3");
    pulse(1'b1, 1'b0, 1'b0);
    check(F_SET, 2, "setting_minute");
    repeat (59) pulse(1'b0, 1'b1, 1'b0);
    check(F_AM, 59, "minute_plus59");
    pulse(1'b0, 1'b1, 1'b0);
    check(F_AM, 0, "minute_wrap");
    pulse(1'b1, 1'b0, 1'b0);
    check(F_SET, 0, "setting_done");

    // Hour wrap 23 -> 0, then back to 10.
    pulse(1'b1, 1'b0, 1'b0);
    repeat (13) pulse(1'b0, 1'b1, 1'b0);
    check(F_AH, 23, "hour_23");
    pulse(1'b0, 1'b1, 1'b0);
    check(F_AH, 0, "hour_wrap");
    repeat (10) pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check(F_AH, 10, "hour_back_10");
    check(F_SET, 2, "setting_minute_again");

    // Match during SET_MINUTE ignored; leaving with match high does not fire.
    bus.hour = 5'd10; bus.minute = 6'd0;
    match_edge();
    check(F_RING, 0, "match_ignored_in_set");
    check(F_SET, 2, "still_setting_minute");
    pulse(1'b1, 1'b1, 1'b0);
    check(F_SET, 0, "set_wins_over_add");
    check(F_AM, 0, "add_suppressed_by_set");
    step(3);
    check(F_RING, 0, "no_fire_leaving_set");

    // Snooze: 300 flags re-ring with ring_cnt=0; key_stop ignored while snoozing.
    match_edge();
    check(F_RING, 1, "ring_for_snooze");
    pulse(1'b0, 1'b0, 1'b1);
    check(F_SNZ, 1, "snooze_entered");
    check(F_RING, 0, "snooze_not_ringing");
    check(F_BUZ, 0, "snooze_buzzer_off");
    repeat (100) flag();
    pulse(1'b0, 1'b0, 1'b1);
    check(F_SNZ, 1, "stop_ignored_in_snooze");
    repeat (199) flag();
    check(F_SNZ, 1, "snooze_before_expiry");
    check(F_RING, 0, "not_ringing_before_expiry");
    bus.second_flag = 1'b1;
    step();
    bus.second_flag = 1'b0;
    check(F_RING, 1, "ring_after_snooze");
    check(F_SNZ, 0, "snooze_left");
    check(F_BUZ, 0, "buzz_after_snooze_early", 15);
    check(F_BUZ, 1, "buzz_after_snooze", 16);
    step(17);
    flag();
    check(F_BUZ, 0, "buzz_odd_after_snooze");
    pulse(1'b0, 1'b0, 1'b1);
    check(F_SNZ, 1, "snooze_again");
    pulse(1'b1, 1'b0, 1'b0);
    check(F_SNZ, 0, "dismiss_snooze");
    check(F_RING, 0, "dismiss_snooze_ring");
    check(F_SET, 0, "dismiss_snooze_setting");

    // key_set and key_stop together while ringing: dismiss.
    match_edge();
    check(F_RING, 1, "ring_for_dual_key");
    pulse(1'b1, 1'b0, 1'b1);
    check(F_RING, 0, "dual_key_ring");
    check(F_SNZ, 0, "dual_key_not_snooze");
    check(F_SET, 0, "dual_key_not_setting");

    // Disable while buzzing.
    match_edge();
    step(16);
    check(F_BUZ, 1, "buzz_before_disable");
    bus.alarm_enable = 1'b0;
    step();
    check(F_RING, 0, "disable_ring");
    check(F_BUZ, 0, "disable_buzzer");
    match_edge();
    step();
    check(F_RING, 0, "no_ring_disabled");

    // Asynchronous reset in the middle of a snooze.
    bus.alarm_enable = 1'b1;
    match_edge();
    check(F_RING, 1, "ring_before_reset");
    pulse(1'b0, 1'b0, 1'b1);
    check(F_SNZ, 1, "snooze_before_reset");
    step();
    reset = 1'b0;
    #1;
    check(F_SNZ, 0, "async_reset_snooze");
    check(F_RING, 0, "async_reset_ring");
    check(F_AH, 7, "async_reset_hour");
    check(F_AM, 0, "async_reset_minute");
    step(2);
    reset = 1'b1;
    step(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
